// File: rtl/gc_pkg.sv
// Shared definitions for the GameCube controller single-wire link.
package gc_pkg;

    // Well-known host commands, left-aligned (bit 23 goes out first).
    localparam logic [23:0] CMD_INIT            = 24'h000000;
    localparam logic [4:0]  CMD_INIT_LEN        = 5'd8;
    localparam logic [23:0] CMD_POLL            = 24'h400300;
    localparam logic [4:0]  CMD_POLL_LEN        = 5'd24;
    localparam logic [23:0] CMD_WAVEBIRD_ID     = 24'h4E0000;
    localparam logic [4:0]  CMD_WAVEBIRD_ID_LEN = 5'd24;

    // Longest command the shift register can hold.
    localparam logic [4:0]  CMD_MAX_LEN = 5'd24;

    // Low-time multiples of the 1 us quantum; every bit cell is BIT_MULT quanta.
    localparam int LOW_MULT_ONE  = 1;
    localparam int LOW_MULT_ZERO = 3;
    localparam int BIT_MULT      = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_LOW  = 3'd1,
        BIT_HIGH = 3'd2,
        STOP_LOW = 3'd3,
        GUARD    = 3'd4
    } gc_tx_state_t;

    // Lengths beyond the shift register are treated as a full 24-bit command.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > CMD_MAX_LEN) ? CMD_MAX_LEN : len;
    endfunction

endpackage

// File: rtl/gc_tx_timer.sv
// Loadable 16-bit down-counter; expired is high while the count sits at zero.
module gc_tx_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_expired
);

    logic [15:0] r_count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_expired = (r_count == 16'd0);

endmodule

// File: rtl/gc_transmit.sv
// GameCube host-to-controller command serialiser driving an open-drain pad.
module gc_transmit
    import gc_pkg::*;
#(
    parameter int CYCLES_PER_US = 100,
    parameter int GUARD_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] cmd,
    input  logic [4:0]  cmd_len,
    output logic        data_oe,
    output logic        send,
    output logic        busy,
    output logic        done
);

    // Phase durations are loaded as length-1 so the timer hits zero on the last cycle.
    localparam logic [15:0] T_LOW_ONE   = 16'(LOW_MULT_ONE * CYCLES_PER_US - 1);
    localparam logic [15:0] T_LOW_ZERO  = 16'(LOW_MULT_ZERO * CYCLES_PER_US - 1);
    localparam logic [15:0] T_HIGH_ONE  = 16'((BIT_MULT - LOW_MULT_ONE) * CYCLES_PER_US - 1);
    localparam logic [15:0] T_HIGH_ZERO = 16'((BIT_MULT - LOW_MULT_ZERO) * CYCLES_PER_US - 1);
    localparam logic [15:0] T_STOP      = 16'(CYCLES_PER_US - 1);
    localparam logic [15:0] T_GUARD     = 16'(GUARD_CYCLES - 1);

    gc_tx_state_t r_state;
    gc_tx_state_t w_next_state;
    logic [23:0]  r_shift;
    logic [4:0]   r_bits;
    logic         r_oe;
    logic         r_send;
    logic         r_busy;
    logic         r_done;
    logic         w_load;
    logic [15:0]  w_load_val;
    logic         w_accept;
    logic         w_advance;
    logic         w_expired;
    logic [4:0]   w_len;

    function automatic logic [15:0] low_time(input logic b);
        return b ? T_LOW_ONE : T_LOW_ZERO;
    endfunction

    function automatic logic [15:0] high_time(input logic b);
        return b ? T_HIGH_ONE : T_HIGH_ZERO;
    endfunction

    assign w_len = clamp_len(cmd_len);

    gc_tx_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // Next-state logic; each transition reloads the timer for the phase it enters.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 16'd0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    if (w_len != 5'd0) begin
                        w_next_state = BIT_LOW;
                        w_load_val   = low_time(cmd[23]);
                    end else begin
                        w_next_state = STOP_LOW;
                        w_load_val   = T_STOP;
                    end
                end
            end
            BIT_LOW: begin
                if (w_expired) begin
                    w_next_state = BIT_HIGH;
                    w_load       = 1'b1;
                    w_load_val   = high_time(r_shift[23]);
                end
            end
            BIT_HIGH: begin
                if (w_expired) begin
                    w_advance = 1'b1;
                    w_load    = 1'b1;
                    if (r_bits == 5'd1) begin
                        w_next_state = STOP_LOW;
                        w_load_val   = T_STOP;
                    end else begin
                        // r_shift[22] becomes the MSB once the shift lands.
                        w_next_state = BIT_LOW;
                        w_load_val   = low_time(r_shift[22]);
                    end
                end
            end
            STOP_LOW: begin
                if (w_expired) begin
                    w_next_state = GUARD;
                    w_load       = 1'b1;
                    w_load_val   = T_GUARD;
                end
            end
            GUARD: begin
                if (w_expired) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, command shifter and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= 24'd0;
            r_bits  <= 5'd0;
            r_oe    <= 1'b0;
            r_send  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_oe    <= (w_next_state == BIT_LOW) || (w_next_state == STOP_LOW);
            r_send  <= (w_next_state != IDLE);
            r_busy  <= (w_next_state != IDLE);
            r_done  <= (r_state == GUARD) && (w_next_state == IDLE);
            if (w_accept) begin
                r_shift <= cmd;
                r_bits  <= w_len;
            end else if (w_advance) begin
                r_shift <= {r_shift[22:0], 1'b0};
                r_bits  <= r_bits - 5'd1;
            end
        end
    end

    assign data_oe = r_oe;
    assign send    = r_send;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_gc_transmit.sv
// Directed bench for gc_transmit with a 4-cycle quantum and 8-cycle guard.
module tb_gc_transmit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] cmd;
    logic [4:0]  cmd_len;
    logic        data_oe;
    logic        send;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    bit tr     [0:2047];
    bit exp_tr [0:2047];
    int exp_len;

    gc_transmit #(
        .CYCLES_PER_US (4),
        .GUARD_CYCLES  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cmd     (cmd),
        .cmd_len (cmd_len),
        .data_oe (data_oe),
        .send    (send),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference waveform: per bit, 4 low for a one or 12 low for a zero, padded to 16;
    // then a 4-cycle stop low and 8 released guard cycles.
    task automatic build_expected(input logic [23:0] c, input logic [4:0] l);
        int n;
        int lo;
        logic [23:0] v;
        v = c;
        n = (l > 5'd24) ? 24 : int'(l);
        exp_len = 0;
        for (int i = 0; i < n; i++) begin
            lo = v[23 - i] ? 4 : 12;
            for (int k = 0; k < 16; k++) begin
                exp_tr[exp_len] = (k < lo);
                exp_len++;
            end
        end
        for (int k = 0; k < 12; k++) begin
            exp_tr[exp_len] = (k < 4);
            exp_len++;
        end
    endtask

    // Pulse start for one cycle; leaves us on the negedge of frame cycle 0.
    task automatic start_frame(input logic [23:0] c, input logic [4:0] l);
        @(negedge clk);
        cmd     = c;
        cmd_len = l;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_oe", data_oe, 1);
        check("first_send", send, 1);
        check("first_busy", busy, 1);
    endtask

    // Record data_oe until send falls; optionally disturb start/cmd at one cycle index.
    task automatic capture_frame(input int disturb_at, input logic [23:0] dcmd);
        int t;
        int mism;
        int dseen;
        t = 0;
        mism = 0;
        dseen = 0;
        while (send === 1'b1 && t < 2000) begin
            tr[t] = data_oe;
            if (done) dseen++;
            if (t == disturb_at) begin
                start   = 1'b1;
                cmd     = dcmd;
                cmd_len = 5'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("frame_len", t, exp_len);
        for (int i = 0; i < t && i < exp_len; i++)
            if (tr[i] != exp_tr[i]) mism++;
        check("wave_mismatches", mism, 0);
        check("done_in_frame", dseen, 0);
        check("done_at_end", done, 1);
        check("busy_at_end", busy, 0);
        check("oe_at_end", data_oe, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    task automatic run_cmd(input logic [23:0] c, input logic [4:0] l);
        build_expected(c, l);
        start_frame(c, l);
        capture_frame(-1, 24'd0);
    endtask

    initial begin
        int oe_after;
        reset   = 1'b1;
        start   = 1'b0;
        cmd     = 24'd0;
        cmd_len = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_oe", data_oe, 0);
        check("rst_send", send, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // INIT: eight zero bits, frame length 140.
        run_cmd(24'h000000, 5'd8);
        // POLL: 24 bits mixing ones and zeros.
        run_cmd(24'h400300, 5'd24);
        // WaveBird ID.
        run_cmd(24'h4E0000, 5'd24);
        // Over-length request behaves like 24 bits.
        run_cmd(24'hA5C3F0, 5'd31);
        // Wake pulse only: 4 low, 8 guard, done at cycle 12.
        run_cmd(24'hFFFFFF, 5'd0);
        // Single one-bit.
        run_cmd(24'h800000, 5'd1);

        // Second start and new cmd mid-frame must not alter the frame.
        build_expected(24'h400300, 5'd24);
        start_frame(24'h400300, 5'd24);
        capture_frame(30, 24'hFFFFFF);
        oe_after = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_oe || busy || done) oe_after++;
            @(negedge clk);
        end
        check("no_second_frame", oe_after, 0);

        // Asynchronous reset in the middle of a low phase.
        start_frame(24'h000000, 5'd8);
        @(negedge clk);
        check("pre_rst_oe", data_oe, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_oe", data_oe, 0);
        check("async_rst_send", send, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_oe", data_oe, 0);
        check("post_rst_busy", busy, 0);
        run_cmd(24'h4E0000, 5'd24);

        // Start coinciding with the done edge is ignored; one cycle later it is taken.
        start_frame(24'h000000, 5'd0);
        repeat (11) @(negedge clk);
        check("last_guard_send", send, 1);
        check("last_guard_oe", data_oe, 0);
        start = 1'b1;
        @(negedge clk);
        check("done_cycle_done", done, 1);
        check("done_cycle_oe", data_oe, 0);
        check("done_cycle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("restart_oe", data_oe, 1);
        check("restart_send", send, 1);
        build_expected(24'h000000, 5'd0);
        capture_frame(-1, 24'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
